// File: rtl/game_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_input_pkg
// Brief    : Shared button identifiers and one-shot state encoding.
// Revision : 1.0
// ============================================================================
package game_input_pkg;

  localparam int unsigned BTN_ID_W = 2;

  typedef logic [BTN_ID_W-1:0] btn_id_t;

  localparam btn_id_t BTN_JUMP  = 2'd0;
  localparam btn_id_t BTN_LEFT  = 2'd1;
  localparam btn_id_t BTN_RIGHT = 2'd2;
  localparam btn_id_t BTN_RUN   = 2'd3;

  typedef enum logic [1:0] {
    OS_IDLE  = 2'd0,
    OS_PRESS = 2'd1,
    OS_HOLD  = 2'd2
  } oneshot_state_e;

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : 2-flop synchroniser, debounce counter and press one-shot.
// Revision : 1.0
// ============================================================================
module button_conditioner
  import game_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic button_i,
  output logic held_o,
  output logic press_pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  oneshot_state_e   state_q, state_d;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      state_q <= OS_IDLE;
    end else begin
      sync_q  <= {sync_q[0], button_i};
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      state_q <= state_d;
    end
  end

  // Any cycle where the synced level matches held restarts the stability window.
  always_comb begin
    cnt_d  = '0;
    held_d = held_q;
    if (sync_q[1] != held_q) begin
      if (cnt_q == CNT_MAX) begin
        held_d = ~held_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    press_pulse_o = 1'b0;
    case (state_q)
      OS_IDLE: begin
        if (held_q) state_d = OS_PRESS;
      end
      OS_PRESS: begin
        press_pulse_o = 1'b1;
        state_d       = held_q ? OS_HOLD : OS_IDLE;
      end
      OS_HOLD: begin
        if (!held_q) state_d = OS_IDLE;
      end
      default: state_d = OS_IDLE;
    endcase
  end

  assign held_o = held_q;

endmodule
`default_nettype wire

// File: rtl/button_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : button_event_scheduler
// Brief    : Conditions all buttons and schedules press events round-robin into a FIFO.
// Revision : 1.0
// ============================================================================
module button_event_scheduler
  import game_input_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                           vga_clock,
  input  logic                           reset,
  input  logic [NUM_BUTTONS-1:0]         buttons,
  input  logic                           event_pop,
  input  logic                           clear_overflow,
  output logic                           event_valid,
  output logic [$clog2(NUM_BUTTONS)-1:0] event_id,
  output logic [NUM_BUTTONS-1:0]         held,
  output logic                           overflow
);

  localparam int unsigned ID_W  = $clog2(NUM_BUTTONS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [NUM_BUTTONS-1:0] press_pulse;

  generate
    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
        .vga_clock    (vga_clock),
        .reset        (reset),
        .button_i     (buttons[b]),
        .held_o       (held[b]),
        .press_pulse_o(press_pulse[b])
      );
    end
  endgenerate

  logic [NUM_BUTTONS-1:0] pending_q, pending_d, grant_mask;
  logic                   overflow_q, overflow_d;
  logic [ID_W-1:0]        last_grant_q, last_grant_d, grant_id;
  logic                   grant_valid, fifo_full, do_pop;

  logic [ID_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign fifo_full   = (count_q == FULL_COUNT);
  assign event_valid = (count_q != '0);
  assign do_pop      = event_valid && event_pop;
  assign event_id    = event_valid ? fifo_q[rd_ptr_q] : '0;
  assign overflow    = overflow_q;

  // Nearest pending index after last_grant wins; fullness is judged before any pop.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_valid = 1'b0;
    grant_id    = last_grant_q;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_BUTTONS; k++) begin
      idx = ID_W'((32'(last_grant_q) + k) % NUM_BUTTONS);
      if (pending_q[idx] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
    if (fifo_full) grant_valid = 1'b0;
  end

  always_comb begin
    grant_mask = '0;
    if (grant_valid) grant_mask[grant_id] = 1'b1;
    pending_d    = (pending_q & ~grant_mask) | press_pulse;
    overflow_d   = (overflow_q & ~clear_overflow) | (|(press_pulse & pending_q));
    last_grant_d = grant_valid ? grant_id : last_grant_q;
    wr_ptr_d     = grant_valid ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({grant_valid, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      last_grant_q <= ID_W'(NUM_BUTTONS - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (grant_valid) fifo_q[wr_ptr_q] <= grant_id;
    end
  end

endmodule
`default_nettype wire
